// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
// Sequences every write into the frame-buffer RAM and shares its single write
// port between two requesters and a built-in clear engine.
//
// Ports:
//   clk_in, reset           system clock (posedge), async active-high reset
//   req0_* / req1_*         valid/ready write requests with address and data
//   clear_start/clear_value one-cycle pulse that starts a fill of the whole RAM
//   clear_busy/clear_done   sweep in progress / one-cycle completion pulse
//   ram_*                   registered RAM write-port controls
//   grant_owner             0 none, 1 req0, 2 req1, 3 clear engine
//   writes_done             wrapping count of accepted requester writes
module fb_write_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int WRITE_CYCLES = 2,
    parameter logic [ADDR_WIDTH-1:0] CLEAR_LAST = 12'd4095
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  clear_start,
    input  logic [DATA_WIDTH-1:0] clear_value,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  ram_write_enable,
    output logic                  ram_clk_enable,
    output logic [1:0]            grant_owner,
    output logic [15:0]           writes_done
);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    localparam logic [2:0] HOLD_LAST = 3'(WRITE_CYCLES);

    state_t                state;
    logic [2:0]            cycle_cnt;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic [DATA_WIDTH-1:0] clear_fill;
    logic                  rr_ptr;
    logic                  grant0;
    logic                  grant1;

    // rr_ptr = 1 means req1 is preferred on the next contended cycle.
    // clear_start beats both requesters in the same cycle.
    always_comb begin
        grant0 = (state == IDLE) && !clear_start && req0_valid &&
                 (!req1_valid || !rr_ptr);
        grant1 = (state == IDLE) && !clear_start && req1_valid &&
                 (!req0_valid || rr_ptr);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // cycle_cnt counts enable cycles of the current write, starting at 1 on
    // the edge that raises the enables. In CLEAR, 0 marks the single setup
    // cycle between clear_start and the first sweep write.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cycle_cnt        <= '0;
            clear_addr       <= '0;
            clear_fill       <= '0;
            rr_ptr           <= 1'b0;
            clear_busy       <= 1'b0;
            clear_done       <= 1'b0;
            ram_address      <= '0;
            ram_data_out     <= '0;
            ram_write_enable <= 1'b0;
            ram_clk_enable   <= 1'b0;
            grant_owner      <= 2'd0;
            writes_done      <= 16'd0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state       <= CLEAR;
                        clear_fill  <= clear_value;
                        clear_addr  <= '0;
                        cycle_cnt   <= 3'd0;
                        clear_busy  <= 1'b1;
                        grant_owner <= 2'd3;
                    end else if (grant0 || grant1) begin
                        ram_address      <= grant0 ? req0_addr : req1_addr;
                        ram_data_out     <= grant0 ? req0_data : req1_data;
                        ram_write_enable <= 1'b1;
                        ram_clk_enable   <= 1'b1;
                        grant_owner      <= grant0 ? 2'd1 : 2'd2;
                        rr_ptr           <= grant0;
                        writes_done      <= writes_done + 16'd1;
                        cycle_cnt        <= 3'd1;
                        state            <= WRITE;
                    end
                end
                WRITE: begin
                    if (cycle_cnt == HOLD_LAST) begin
                        ram_write_enable <= 1'b0;
                        ram_clk_enable   <= 1'b0;
                        grant_owner      <= 2'd0;
                        state            <= IDLE;
                    end else begin
                        cycle_cnt <= cycle_cnt + 3'd1;
                    end
                end
                CLEAR: begin
                    if (cycle_cnt == 3'd0) begin
                        ram_address      <= '0;
                        ram_data_out     <= clear_fill;
                        ram_write_enable <= 1'b1;
                        ram_clk_enable   <= 1'b1;
                        cycle_cnt        <= 3'd1;
                    end else if (cycle_cnt != HOLD_LAST) begin
                        cycle_cnt <= cycle_cnt + 3'd1;
                    end else if (clear_addr == CLEAR_LAST) begin
                        ram_write_enable <= 1'b0;
                        ram_clk_enable   <= 1'b0;
                        grant_owner      <= 2'd0;
                        clear_busy       <= 1'b0;
                        clear_done       <= 1'b1;
                        state            <= IDLE;
                    end else begin
                        // enables stay high; only the address steps on
                        clear_addr  <= clear_addr + 1'b1;
                        ram_address <= clear_addr + 1'b1;
                        cycle_cnt   <= 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter
// Directed self-checking bench for fb_write_arbiter with default parameters
// (12-bit address, 8-bit data, 2 enable cycles per write, full 4096 sweep).
module tb_fb_write_arbiter;

    logic        clk_in;
    logic        reset;
    logic        req0_valid;
    logic [11:0] req0_addr;
    logic [7:0]  req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [11:0] req1_addr;
    logic [7:0]  req1_data;
    logic        req1_ready;
    logic        clear_start;
    logic [7:0]  clear_value;
    logic        clear_busy;
    logic        clear_done;
    logic [11:0] ram_address;
    logic [7:0]  ram_data_out;
    logic        ram_write_enable;
    logic        ram_clk_enable;
    logic [1:0]  grant_owner;
    logic [15:0] writes_done;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;

    fb_write_arbiter dut (
        .clk_in           (clk_in),
        .reset            (reset),
        .req0_valid       (req0_valid),
        .req0_addr        (req0_addr),
        .req0_data        (req0_data),
        .req0_ready       (req0_ready),
        .req1_valid       (req1_valid),
        .req1_addr        (req1_addr),
        .req1_data        (req1_data),
        .req1_ready       (req1_ready),
        .clear_start      (clear_start),
        .clear_value      (clear_value),
        .clear_busy       (clear_busy),
        .clear_done       (clear_done),
        .ram_address      (ram_address),
        .ram_data_out     (ram_data_out),
        .ram_write_enable (ram_write_enable),
        .ram_clk_enable   (ram_clk_enable),
        .grant_owner      (grant_owner),
        .writes_done      (writes_done)
    );

    // 10-unit free-running clock
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Count every clear_done pulse, sampled away from the active edge
    always @(negedge clk_in) begin
        if (clear_done === 1'b1) done_pulses++;
    end

    // Watchdog so the run can never hang
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge, where outputs are sampled
    // and inputs are changed
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Pulse reset across two edges and return with everything idle
    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Reset state: every output at zero with no requests pending
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({req0_ready, req1_ready, ram_address, ram_data_out, ram_write_enable,
             ram_clk_enable, grant_owner, clear_busy, clear_done, writes_done} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: got addr=%h data=%h we=%b ce=%b go=%0d busy=%b done=%b wd=%0d rdy=%b%b, required all zero",
                     ram_address, ram_data_out, ram_write_enable, ram_clk_enable, grant_owner,
                     clear_busy, clear_done, writes_done, req0_ready, req1_ready);
        end
        reset = 1'b0;
        step();
    endtask

    // A lone req0 write: ready in the same cycle, two enable cycles, then idle
    task automatic test_single_write(input logic [15:0] exp_wd);
        req0_valid = 1'b1;
        req0_addr  = 12'h0A5;
        req0_data  = 8'h3C;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ready: got rdy0=%b rdy1=%b, required 1 0", req0_ready, req1_ready);
        end
        @(posedge clk_in);
        #1;
        // scramble the request after transfer; it must have no effect
        req0_valid = 1'b0;
        req0_addr  = 12'hFFF;
        req0_data  = 8'h00;
        checks++;
        if (ram_address !== 12'h0A5 || ram_data_out !== 8'h3C || ram_write_enable !== 1'b1 ||
            ram_clk_enable !== 1'b1 || grant_owner !== 2'd1 || writes_done !== exp_wd) begin
            errors++;
            $display("[TB] FAIL single_first: got addr=%h data=%h we=%b ce=%b go=%0d wd=%0d, required 0a5 3c 1 1 1 %0d",
                     ram_address, ram_data_out, ram_write_enable, ram_clk_enable, grant_owner, writes_done, exp_wd);
        end
        step();
        checks++;
        if (ram_address !== 12'h0A5 || ram_data_out !== 8'h3C || ram_write_enable !== 1'b1 ||
            ram_clk_enable !== 1'b1 || grant_owner !== 2'd1) begin
            errors++;
            $display("[TB] FAIL single_second: got addr=%h data=%h we=%b ce=%b go=%0d, required 0a5 3c 1 1 1",
                     ram_address, ram_data_out, ram_write_enable, ram_clk_enable, grant_owner);
        end
        step();
        checks++;
        if (ram_address !== 12'h0A5 || ram_data_out !== 8'h3C || ram_write_enable !== 1'b0 ||
            ram_clk_enable !== 1'b0 || grant_owner !== 2'd0 || writes_done !== exp_wd) begin
            errors++;
            $display("[TB] FAIL single_end: got addr=%h data=%h we=%b ce=%b go=%0d wd=%0d, required 0a5 3c 0 0 0 %0d",
                     ram_address, ram_data_out, ram_write_enable, ram_clk_enable, grant_owner, writes_done, exp_wd);
        end
    endtask

    // Both requesters held: alternating grants starting with req0, 3 cycles apart
    task automatic test_back_to_back();
        int winner [4];
        int when   [4];
        int n;
        int got;
        do_reset();
        req0_valid = 1'b1; req0_addr = 12'h111; req0_data = 8'h11;
        req1_valid = 1'b1; req1_addr = 12'h222; req1_data = 8'h22;
        #1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            got = 0;
            if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
                checks++;
                errors++;
                $display("[TB] FAIL contention_both_ready: got rdy0=1 rdy1=1, required one of them");
            end else if (req0_ready === 1'b1) begin
                got = 1;
            end else if (req1_ready === 1'b1) begin
                got = 2;
            end
            step();
            if (got != 0) begin
                winner[n] = got;
                when[n]   = c;
                checks++;
                if (grant_owner !== 2'(got) ||
                    ram_address !== ((got == 1) ? 12'h111 : 12'h222) ||
                    ram_data_out !== ((got == 1) ? 8'h11 : 8'h22)) begin
                    errors++;
                    $display("[TB] FAIL contention_latch%0d: got go=%0d addr=%h data=%h, required go=%0d",
                             n, grant_owner, ram_address, ram_data_out, got);
                end
                n++;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("[TB] FAIL contention_count: got %0d transfers in 40 cycles, required 4", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (winner[i] != ((i % 2 == 0) ? 1 : 2)) begin
                errors++;
                $display("[TB] FAIL contention_order%0d: got req%0d, required req%0d",
                         i, winner[i] - 1, (i % 2));
            end
            if (i > 0) begin
                checks++;
                if (when[i] - when[i-1] != 3) begin
                    errors++;
                    $display("[TB] FAIL contention_gap%0d: got %0d cycles, required 3", i, when[i] - when[i-1]);
                end
            end
        end
        checks++;
        if (writes_done !== 16'd4) begin
            errors++;
            $display("[TB] FAIL contention_writes_done: got %0d, required 4", writes_done);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        step();
    endtask

    // Full FF sweep with req1 held and a stray clear_start mid-sweep
    task automatic test_clear_sweep();
        int bad;
        int first_bad;
        int pulses_before;
        req1_valid  = 1'b1; req1_addr = 12'h222; req1_data = 8'h22;
        clear_start = 1'b1;
        clear_value = 8'hFF;
        pulses_before = done_pulses;
        #1;
        checks++;
        if (req1_ready !== 1'b0 || req0_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_priority: got rdy0=%b rdy1=%b, required 0 0", req0_ready, req1_ready);
        end
        @(posedge clk_in);
        #1;
        clear_start = 1'b0;
        clear_value = 8'h00;
        checks++;
        if (clear_busy !== 1'b1 || ram_write_enable !== 1'b0 || grant_owner !== 2'd3) begin
            errors++;
            $display("[TB] FAIL clear_setup: got busy=%b we=%b go=%0d, required 1 0 3",
                     clear_busy, ram_write_enable, grant_owner);
        end
        bad = 0;
        first_bad = -1;
        for (int j = 1; j <= 8192; j++) begin
            step();
            if (j == 50) clear_start = 1'b1;
            if (j == 51) clear_start = 1'b0;
            if (ram_address !== 12'((j - 1) / 2) || ram_data_out !== 8'hFF ||
                ram_write_enable !== 1'b1 || ram_clk_enable !== 1'b1 || clear_busy !== 1'b1 ||
                clear_done !== 1'b0 || req1_ready !== 1'b0 || grant_owner !== 2'd3) begin
                bad++;
                if (first_bad < 0) first_bad = j;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL clear_sweep: got %0d bad cycles (first at cycle %0d), required 0", bad, first_bad);
        end
        step();
        checks++;
        if (clear_done !== 1'b1 || clear_busy !== 1'b0 || ram_write_enable !== 1'b0 ||
            ram_clk_enable !== 1'b0 || grant_owner !== 2'd0 || req1_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_finish: got done=%b busy=%b we=%b ce=%b go=%0d rdy1=%b, required 1 0 0 0 0 1",
                     clear_done, clear_busy, ram_write_enable, ram_clk_enable, grant_owner, req1_ready);
        end
        step();
        req1_valid = 1'b0;
        checks++;
        if (grant_owner !== 2'd2 || ram_address !== 12'h222 || ram_data_out !== 8'h22 || clear_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_then_req1: got go=%0d addr=%h data=%h done=%b, required 2 222 22 0",
                     grant_owner, ram_address, ram_data_out, clear_done);
        end
        step();
        step();
        checks++;
        if (done_pulses - pulses_before != 1) begin
            errors++;
            $display("[TB] FAIL clear_done_once: got %0d pulses, required 1", done_pulses - pulses_before);
        end
    endtask

    // clear_start and req0_valid together: the clear wins, req0 waits its turn
    task automatic test_clear_vs_req0();
        int bad;
        int steps;
        logic seen;
        clear_start = 1'b1;
        clear_value = 8'h00;
        req0_valid  = 1'b1; req0_addr = 12'h0B0; req0_data = 8'h5A;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clearvs_ready: got rdy0=%b, required 0", req0_ready);
        end
        @(posedge clk_in);
        #1;
        clear_start = 1'b0;
        bad = 0;
        steps = 0;
        seen = 1'b0;
        for (int c = 0; c < 9000 && !seen; c++) begin
            step();
            steps++;
            if (clear_done === 1'b1) seen = 1'b1;
            else if (req0_ready !== 1'b0 || clear_busy !== 1'b1) bad++;
        end
        checks++;
        if (!seen || steps != 8193 || bad != 0) begin
            errors++;
            $display("[TB] FAIL clearvs_sweep: got done_seen=%b after %0d cycles with %0d bad, required 1 8193 0",
                     seen, steps, bad);
        end
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clearvs_ready_after: got rdy0=%b, required 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        checks++;
        if (grant_owner !== 2'd1 || ram_address !== 12'h0B0 || ram_data_out !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL clearvs_req0_served: got go=%0d addr=%h data=%h, required 1 0b0 5a",
                     grant_owner, ram_address, ram_data_out);
        end
        step();
        step();
    endtask

    // Reset during the 100th clear write aborts the sweep with no done pulse
    task automatic test_reset_mid_clear();
        int pulses_before;
        clear_start = 1'b1;
        clear_value = 8'hAA;
        pulses_before = done_pulses;
        step();
        clear_start = 1'b0;
        repeat (199) step();
        checks++;
        if (ram_address !== 12'd99 || ram_data_out !== 8'hAA || ram_write_enable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midclear_position: got addr=%0d data=%h we=%b, required 99 aa 1",
                     ram_address, ram_data_out, ram_write_enable);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, ram_address, ram_data_out, ram_write_enable,
             ram_clk_enable, grant_owner, clear_busy, clear_done, writes_done} !== '0) begin
            errors++;
            $display("[TB] FAIL midclear_reset: got addr=%h data=%h we=%b ce=%b go=%0d busy=%b done=%b wd=%0d, required all zero",
                     ram_address, ram_data_out, ram_write_enable, ram_clk_enable, grant_owner,
                     clear_busy, clear_done, writes_done);
        end
        step();
        reset = 1'b0;
        repeat (4) step();
        checks++;
        if (done_pulses != pulses_before || clear_busy !== 1'b0 || ram_write_enable !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midclear_no_resume: got pulses=%0d busy=%b we=%b, required 0 0 0",
                     done_pulses - pulses_before, clear_busy, ram_write_enable);
        end
        test_single_write(16'd1);
    endtask

    // writes_done rolls over from FFFF to 0 on the next accepted write
    task automatic test_wrap();
        step();
        force dut.writes_done = 16'hFFFF;
        step();
        release dut.writes_done;
        #1;
        checks++;
        if (writes_done !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL wrap_preload: got %h, required ffff", writes_done);
        end
        req1_valid = 1'b1; req1_addr = 12'h333; req1_data = 8'h33;
        @(posedge clk_in);
        #1;
        req1_valid = 1'b0;
        checks++;
        if (writes_done !== 16'h0000 || grant_owner !== 2'd2 || ram_address !== 12'h333) begin
            errors++;
            $display("[TB] FAIL wrap_rollover: got wd=%h go=%0d addr=%h, required 0000 2 333",
                     writes_done, grant_owner, ram_address);
        end
        step();
        step();
    endtask

    // Run every scenario in order, then report
    initial begin
        reset       = 1'b1;
        req0_valid  = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid  = 1'b0; req1_addr = '0; req1_data = '0;
        clear_start = 1'b0;
        clear_value = '0;
        test_reset();
        test_single_write(16'd1);
        test_back_to_back();
        test_clear_sweep();
        test_clear_vs_req0();
        test_reset_mid_clear();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
